uart_fifo_core: RTL

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_fifo_core_pkg.sv | 17 +
 rtl/uart_sfifo.sv | 69 ++++++
 rtl/uart_fifo_core.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_core_pkg.sv
// rtl/uart_fifo_core_pkg.sv - shared FSM state encoding and constants for uart_fifo_core
// The PARITY state exists only when UART_FIFO_CORE_PARITY_EN is defined.
package uart_fifo_core_pkg;

  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_FIFO_CORE_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sfifo.sv
// rtl/uart_sfifo.sv - synchronous FIFO with occupancy output and optional first-word-fall-through
module uart_sfifo #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4,
  parameter bit FWFT    = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cke_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic               wvalid_i,
  output logic               wready_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rvalid_o,
  input  logic               rready_i,
  output logic [FIFO_AW:0]   level_o
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               full, push, pop;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept a write.
  always_comb begin
    full    = (level_q == (FIFO_AW+1)'(DEPTH));
    pop     = rready_i & (level_q != '0);
    push    = wvalid_i & (~full | pop);
    wptr_d  = push ? wptr_q + FIFO_AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + FIFO_AW'(1) : rptr_q;
    level_d = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (cke_i) begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && cke_i && push) mem_q[wptr_q] <= wdata_i;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata_o = mem_q[rptr_q];
    end else begin : g_reg
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) rdata_q <= '0;
        else if (cke_i && pop) rdata_q <= mem_q[rptr_q];
      end
      assign rdata_o = rdata_q;
    end
  endgenerate

  assign wready_o = ~full;
  assign rvalid_o = (level_q != '0);
  assign level_o  = level_q;

endmodule

// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART transmitter/receiver with TX and RX FIFOs and RTS/CTS flow control
// Define UART_FIFO_CORE_PARITY_EN to add parity generation and checking.
module uart_fifo_core
  import uart_fifo_core_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4,
  parameter int DIV_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cke_i,
  input  logic               soft_rst_i,
  input  logic               tx_en_i,
  input  logic               rx_en_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic               stop2_i,
  input  logic               parity_odd_i,
  input  logic [DATA_W-1:0]  tx_wdata_i,
  input  logic               tx_wvalid_i,
  output logic               tx_wready_o,
  output logic [DATA_W-1:0]  rx_rdata_o,
  output logic               rx_rvalid_o,
  input  logic               rx_rready_i,
  output logic [FIFO_AW:0]   tx_level_o,
  output logic [FIFO_AW:0]   rx_level_o,
  output logic               rx_overrun_o,
  output logic               rx_frame_err_o,
  output logic               rx_parity_err_o,
  output logic               txd_o,
  input  logic               rxd_i,
  input  logic               cts_i,
  output logic               rts_o
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic              rst;
  logic [DIV_W-1:0]  div_eff;
  logic              rxd_s1_q, rxd_s2_q, rxd_s3_q, cts_s1_q, cts_s2_q;

  logic [DATA_W-1:0] tx_head;
  logic              tx_nempty, tx_pop;
  logic              rx_wready, rx_pop;

  uart_state_e       tx_state_q, tx_state_d;
  logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic              tx_stop2_q, tx_stop2_d, tx_stopn_q, tx_stopn_d;
  logic              txd_q, txd_d, tx_last;

  uart_state_e       rx_state_q, rx_state_d;
  logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              rx_wr_q, rx_wr_d, rx_last, rx_half;
  logic              frame_err_q, frame_err_d, ovr_q, ovr_d;

`ifdef UART_FIFO_CORE_PARITY_EN
  logic              tx_par_q, tx_par_d, rx_odd_q, rx_odd_d, par_err_q, par_err_d;
`else
  logic              parity_unused;
  assign parity_unused = parity_odd_i;
`endif

  assign rst     = rst_i | soft_rst_i;
  assign div_eff = (div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_i;
  assign rx_pop  = rx_rvalid_o & rx_rready_i;

  uart_sfifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .FWFT(1'b1)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst), .cke_i(cke_i),
    .wdata_i(tx_wdata_i), .wvalid_i(tx_wvalid_i), .wready_o(tx_wready_o),
    .rdata_o(tx_head), .rvalid_o(tx_nempty), .rready_i(tx_pop),
    .level_o(tx_level_o)
  );

  uart_sfifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .FWFT(1'b1)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst), .cke_i(cke_i),
    .wdata_i(rx_sh_q), .wvalid_i(rx_wr_q), .wready_o(rx_wready),
    .rdata_o(rx_rdata_o), .rvalid_o(rx_rvalid_o), .rready_i(rx_rready_i),
    .level_o(rx_level_o)
  );

  // Transmitter: txd is registered and updated on each bit boundary.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_stop2_d = tx_stop2_q;
    tx_stopn_d = tx_stopn_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
`ifdef UART_FIFO_CORE_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_last    = (tx_cnt_q == tx_div_q - DIV_W'(1));
    if (tx_state_q != ST_IDLE) tx_cnt_d = tx_last ? '0 : tx_cnt_q + DIV_W'(1);
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (tx_en_i && tx_nempty && cts_s2_q) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_div_d   = div_eff;
          tx_stop2_d = stop2_i;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
`ifdef UART_FIFO_CORE_PARITY_EN
          tx_par_d   = ^tx_head ^ parity_odd_i;
`endif
        end
      end
      ST_START: begin
        if (tx_last) begin
          txd_d      = tx_sh_q[0];
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_last) begin
          if (tx_bit_q == 3'(DATA_W - 1)) begin
`ifdef UART_FIFO_CORE_PARITY_EN
            txd_d      = tx_par_q;
            tx_state_d = ST_PARITY;
`else
            txd_d      = 1'b1;
            tx_stopn_d = 1'b0;
            tx_state_d = ST_STOP;
`endif
          end else begin
            txd_d    = tx_sh_q[1];
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_FIFO_CORE_PARITY_EN
      ST_PARITY: begin
        if (tx_last) begin
          txd_d      = 1'b1;
          tx_stopn_d = 1'b0;
          tx_state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tx_last) begin
          if (tx_stop2_q && !tx_stopn_q) tx_stopn_d = 1'b1;
          else tx_state_d = ST_IDLE;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // Receiver: start bit checked at half bit-time, later bits one bit-time apart.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_wr_d     = 1'b0;
    frame_err_d = frame_err_q;
    ovr_d       = ovr_q | (rx_wr_q & ~rx_wready & ~rx_pop);
`ifdef UART_FIFO_CORE_PARITY_EN
    rx_odd_d    = rx_odd_q;
    par_err_d   = par_err_q;
`endif
    rx_last     = (rx_cnt_q == rx_div_q - DIV_W'(1));
    rx_half     = (rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1));
    if (rx_state_q != ST_IDLE) rx_cnt_d = rx_last ? '0 : rx_cnt_q + DIV_W'(1);
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_en_i && rxd_s3_q && !rxd_s2_q) begin
          rx_cnt_d   = '0;
          rx_div_d   = div_eff;
          rx_state_d = ST_START;
`ifdef UART_FIFO_CORE_PARITY_EN
          rx_odd_d   = parity_odd_i;
`endif
        end
      end
      ST_START: begin
        if (rx_half) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_last) begin
          rx_sh_d = {rxd_s2_q, rx_sh_q[DATA_W-1:1]};
          if (rx_bit_q == 3'(DATA_W - 1)) begin
`ifdef UART_FIFO_CORE_PARITY_EN
            rx_state_d = ST_PARITY;
`else
            rx_state_d = ST_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_FIFO_CORE_PARITY_EN
      ST_PARITY: begin
        if (rx_last) begin
          if (rxd_s2_q != (^rx_sh_q ^ rx_odd_q)) par_err_d = 1'b1;
          rx_state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (rx_last) begin
          if (rxd_s2_q) rx_wr_d = 1'b1;
          else frame_err_d = 1'b1;
          rx_state_d = ST_IDLE;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_s3_q    <= 1'b1;
      cts_s1_q    <= 1'b1;
      cts_s2_q    <= 1'b1;
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_div_q    <= DIV_W'(MIN_DIV);
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_stop2_q  <= 1'b0;
      tx_stopn_q  <= 1'b0;
      txd_q       <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_div_q    <= DIV_W'(MIN_DIV);
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_wr_q     <= 1'b0;
      frame_err_q <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef UART_FIFO_CORE_PARITY_EN
      tx_par_q    <= 1'b0;
      rx_odd_q    <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else if (cke_i) begin
      rxd_s1_q    <= rxd_i;
      rxd_s2_q    <= rxd_s1_q;
      rxd_s3_q    <= rxd_s2_q;
      cts_s1_q    <= cts_i;
      cts_s2_q    <= cts_s1_q;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_stopn_q  <= tx_stopn_d;
      txd_q       <= txd_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_wr_q     <= rx_wr_d;
      frame_err_q <= frame_err_d;
      ovr_q       <= ovr_d;
`ifdef UART_FIFO_CORE_PARITY_EN
      tx_par_q    <= tx_par_d;
      rx_odd_q    <= rx_odd_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign txd_o          = txd_q;
  assign rx_overrun_o   = ovr_q;
  assign rx_frame_err_o = frame_err_q;
`ifdef UART_FIFO_CORE_PARITY_EN
  assign rx_parity_err_o = par_err_q;
`else
  assign rx_parity_err_o = 1'b0;
`endif
  assign rts_o = rx_en_i & ~rst & (rx_level_o <= (FIFO_AW+1)'(DEPTH - 2));

endmodule
